// File: rtl/xout_window_accum_pkg.sv
// Shared types and helpers for the XOUT window accumulator.
package xout_pkg;

  // ACCUM: gathering samples of the current window.
  // HOLD:  a finished window total is waiting for the sink.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Width of the emitted-window counter; it wraps naturally.
  localparam int CNT_W = 16;

  // Sum width that holds n full-scale dw-bit samples without overflow.
  function automatic int sum_width(input int dw, input int n);
    return dw + $clog2(n);
  endfunction

endpackage

// File: rtl/xout_window_accum_window_counter.sv
// Sample index within the current window. The index wraps to zero on
// i_clear, and flags the first and the last sample position of a window.
module window_counter #(
  parameter int NSAMPLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_advance,
  input  logic i_clear,
  output logic o_first,
  output logic o_last
);

  localparam int IW = (NSAMPLES > 1) ? $clog2(NSAMPLES) : 1;

  logic [IW-1:0] r_idx;

  // Index register: clear wins over advance so a closing sample restarts at 0.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (i_rst) begin
      r_idx <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_advance) begin
      r_idx <= r_idx + IW'(1);
    end
  end

  assign o_first = (r_idx == '0);
  assign o_last  = (r_idx == IW'(NSAMPLES - 1));

endmodule

// File: rtl/xout_window_accum.sv
// Sums fixed windows of NSAMPLES accepted XOUT samples and presents each
// total on a valid/ready output. Sink backpressure stalls input acceptance.
// Optional feature: define XOUT_WINDOW_MINMAX_EN to add SUM_MIN/SUM_MAX,
// the smallest and largest sample of each emitted window.
module xout_window_accum
  import xout_pkg::*;
#(
  parameter int DW       = 8,
  parameter int NSAMPLES = 4,
  parameter int SW       = sum_width(DW, NSAMPLES)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DW-1:0]    DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic [SW-1:0]    SUM_OUT,
  output logic             SUM_VALID,
  input  logic             SUM_READY,
  output logic [CNT_W-1:0] SUM_CNT
`ifdef XOUT_WINDOW_MINMAX_EN
  ,
  output logic [DW-1:0]    SUM_MIN,
  output logic [DW-1:0]    SUM_MAX
`endif
);

  state_t           r_state;
  state_t           w_state_next;
  logic [SW-1:0]    r_acc;
  logic [SW-1:0]    r_sum;
  logic [CNT_W-1:0] r_sum_cnt;

  logic             w_accept;
  logic             w_handshake;
  logic             w_first;
  logic             w_last;
  logic             w_close;
  logic [SW-1:0]    w_din_ext;
  logic [SW-1:0]    w_total;

  // A held total blocks input unless the sink takes it this very cycle.
  assign SUM_VALID   = (r_state == HOLD);
  assign DIN_READY   = !SUM_VALID || SUM_READY;
  assign w_accept    = DIN_VALID && DIN_READY;
  assign w_handshake = SUM_VALID && SUM_READY;
  assign w_close     = w_accept && w_last;
  assign w_din_ext   = SW'(DIN);
  assign w_total     = r_acc + w_din_ext;

  window_counter #(
    .NSAMPLES (NSAMPLES)
  ) u_window_counter (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_advance (w_accept),
    .i_clear   (w_close),
    .o_first   (w_first),
    .o_last    (w_last)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: closing a window always (re)enters HOLD, even when the
  // previous total is consumed in the same cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_next unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    case (r_state)
      ACCUM: begin
        if (w_close) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (w_close) begin
          w_state_next = HOLD;
        end else if (w_handshake) begin
          w_state_next = ACCUM;
        end
      end
      default: w_state_next = ACCUM;
    endcase
  end

  // Accumulator, registered window total and emitted-window counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc     <= '0;
      r_sum     <= '0;
      r_sum_cnt <= '0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_acc <= '0;
        end else if (w_first) begin
          r_acc <= w_din_ext;
        end else begin
          r_acc <= w_total;
        end
      end
      if (w_close) begin
        r_sum <= w_total;
      end
      if (w_handshake) begin
        r_sum_cnt <= r_sum_cnt + CNT_W'(1);
      end
    end
  end

  assign SUM_OUT = r_sum;
  assign SUM_CNT = r_sum_cnt;

`ifdef XOUT_WINDOW_MINMAX_EN
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_max;
  logic [DW-1:0] r_sum_min;
  logic [DW-1:0] r_sum_max;
  logic [DW-1:0] w_min_next;
  logic [DW-1:0] w_max_next;

  // Running extremes including the current sample; the first sample seeds them.
  always_comb begin
    w_min_next = r_min;
    w_max_next = r_max;
    if (w_first) begin
      w_min_next = DIN;
      w_max_next = DIN;
    end else begin
      if (DIN < r_min) begin
        w_min_next = DIN;
      end
      if (DIN > r_max) begin
        w_max_next = DIN;
      end
    end
  end

  // Trackers follow accepted samples; emitted extremes load with SUM_OUT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_min     <= '0;
      r_max     <= '0;
      r_sum_min <= '0;
      r_sum_max <= '0;
    end else begin
      if (w_accept) begin
        r_min <= w_min_next;
        r_max <= w_max_next;
      end
      if (w_close) begin
        r_sum_min <= w_min_next;
        r_sum_max <= w_max_next;
      end
    end
  end

  assign SUM_MIN = r_sum_min;
  assign SUM_MAX = r_sum_max;
`endif

endmodule
